// File: rtl/frame_scheduler_if.sv
// Framebuffer port bundle shared by the frame scheduler, the drawing engine,
// the flasher and the framebuffer memory.
interface frame_scheduler_if #(
   parameter int unsigned ADDR_W  = 15,
   parameter int unsigned COLOR_W = 3
);
   logic [ADDR_W-1:0]  draw_addr;
   logic [COLOR_W-1:0] draw_data;
   logic               draw_we;
   logic               draw_done;
   logic               draw_gnt;

   logic [ADDR_W-1:0]  flash_addr;
   logic               flash_done;
   logic               flash_start;
   logic               flash_ack;

   logic [ADDR_W-1:0]  mem_addr;
   logic [COLOR_W-1:0] mem_wdata;
   logic               mem_we;

   // The scheduler owns the framebuffer port, so it is the master side.
   modport master (
      input  draw_addr, draw_data, draw_we, draw_done,
      input  flash_addr, flash_done,
      output draw_gnt, flash_start, flash_ack,
      output mem_addr, mem_wdata, mem_we
   );

   modport slave (
      output draw_addr, draw_data, draw_we, draw_done,
      output flash_addr, flash_done,
      input  draw_gnt, flash_start, flash_ack,
      input  mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: grants the framebuffer port to the drawer, then hands
// it to the flasher via the continuation handshake, and counts finished frames.
module frame_scheduler #(
   parameter int unsigned ADDR_W       = 15,
   parameter int unsigned COLOR_W      = 3,
   parameter int unsigned DRAW_TIMEOUT = 65535,
   parameter int unsigned CNT_W        = 8
) (
   input  logic                Clck,
   input  logic                Reset,
   input  logic                frame_tick,
   frame_scheduler_if.master   bus,
   output logic [CNT_W-1:0]    frame_count,
   output logic                busy,
   output logic                overrun,
   output logic                timed_out
);

   localparam int unsigned TMR_W = (DRAW_TIMEOUT > 2) ? $clog2(DRAW_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TO_LAST =
      TMR_W'((DRAW_TIMEOUT == 0) ? 0 : DRAW_TIMEOUT - 1);
   localparam bit TIMEOUT_EN = (DRAW_TIMEOUT != 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAW  = 2'd1,
      S_FLASH = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic               pending_q;
   logic [TMR_W-1:0]   timer_q;
   logic               timeout_hit;
   logic               frame_end;

   always_ff @(posedge Clck or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A draw_done coinciding with the timeout wins, so the
   // timeout flag is raised only when the drawer really failed to finish.
   always_comb begin
      state_d     = state_q;
      timeout_hit = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (frame_tick || pending_q) begin
               state_d = S_DRAW;
            end
         end
         S_DRAW: begin
            if (bus.draw_done) begin
               state_d = S_FLASH;
            end else if (TIMEOUT_EN && (timer_q == TO_LAST)) begin
               state_d     = S_FLASH;
               timeout_hit = 1'b1;
            end
         end
         S_FLASH: begin
            if (bus.flash_done) begin
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (!bus.flash_done) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign frame_end = (state_q == S_ACK) && (state_d == S_IDLE);

   // Port mux and handshake strobes depend on the state register only, so
   // reset forces every one of them low without waiting for a clock.
   always_comb begin
      bus.draw_gnt    = 1'b0;
      bus.flash_start = 1'b0;
      bus.flash_ack   = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wdata   = '0;
      bus.mem_we      = 1'b0;
      busy            = (state_q != S_IDLE);
      unique case (state_q)
         S_DRAW: begin
            bus.draw_gnt  = 1'b1;
            bus.mem_addr  = bus.draw_addr;
            bus.mem_wdata = bus.draw_data;
            bus.mem_we    = bus.draw_we;
         end
         S_FLASH: begin
            bus.flash_start = 1'b1;
            bus.mem_addr    = bus.flash_addr;
         end
         S_ACK: begin
            bus.flash_ack = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Tick queue, draw timer, frame counter and sticky status flags.
   always_ff @(posedge Clck or negedge Reset) begin
      if (!Reset) begin
         pending_q   <= 1'b0;
         timer_q     <= '0;
         frame_count <= '0;
         overrun     <= 1'b0;
         timed_out   <= 1'b0;
      end else begin
         if (state_q == S_IDLE) begin
            pending_q <= 1'b0;
         end else if (frame_tick) begin
            if (pending_q) begin
               overrun <= 1'b1;
            end else begin
               pending_q <= 1'b1;
            end
         end

         if (state_q == S_DRAW) begin
            timer_q <= timer_q + TMR_W'(1);
         end else begin
            timer_q <= '0;
         end

         if (timeout_hit) begin
            timed_out <= 1'b1;
         end

         if (frame_end) begin
            frame_count <= frame_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: directed scenarios, a vector table and a random
// run, all compared every cycle against a frame-level reference model.
module tb_frame_scheduler;

   localparam int unsigned AW   = 15;
   localparam int unsigned CW   = 3;
   localparam int unsigned TO   = 16;
   localparam int unsigned CNTW = 8;

   localparam int PH_IDLE  = 0;
   localparam int PH_DRAW  = 1;
   localparam int PH_FLASH = 2;
   localparam int PH_ACK   = 3;

   logic            Clck;
   logic            Reset;
   logic            frame_tick;
   logic [CNTW-1:0] frame_count;
   logic            busy;
   logic            overrun;
   logic            timed_out;

   frame_scheduler_if #(.ADDR_W(AW), .COLOR_W(CW)) bus ();

   frame_scheduler #(
      .ADDR_W(AW), .COLOR_W(CW), .DRAW_TIMEOUT(TO), .CNT_W(CNTW)
   ) dut (
      .Clck        (Clck),
      .Reset       (Reset),
      .frame_tick  (frame_tick),
      .bus         (bus),
      .frame_count (frame_count),
      .busy        (busy),
      .overrun     (overrun),
      .timed_out   (timed_out)
   );

   initial Clck = 1'b0;
   always #5 Clck = ~Clck;

   int checks   = 0;
   int failures = 0;

   // Reference model: which phase of the frame we are in, how many ticks are
   // waiting, how long the drawer has held the port, and the frame total.
   int m_ph;
   int m_queued;
   int m_draw_len;
   int m_frames;
   bit m_over;
   bit m_to;

   typedef struct {
      bit       tick;
      bit       ddone;
      bit       dwe;
      bit       fdone;
      bit [4:0] exp;   // {busy, gnt, start, ack, we}
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] act_vec();
      return 64'({bus.draw_gnt, busy, bus.flash_start, bus.flash_ack, bus.mem_we,
                  bus.mem_addr, bus.mem_wdata, frame_count, overrun, timed_out});
   endfunction

   function automatic logic [63:0] model_vec();
      logic [AW-1:0] a;
      logic [CW-1:0] d;
      bit            we;
      a  = '0;
      d  = '0;
      we = 1'b0;
      if (m_ph == PH_DRAW) begin
         a  = bus.draw_addr;
         d  = bus.draw_data;
         we = bus.draw_we;
      end else if (m_ph == PH_FLASH) begin
         a = bus.flash_addr;
      end
      return 64'({m_ph == PH_DRAW, m_ph != PH_IDLE, m_ph == PH_FLASH, m_ph == PH_ACK, we,
                  a, d, CNTW'(m_frames % 256), m_over, m_to});
   endfunction

   task automatic model_reset();
      m_ph = PH_IDLE; m_queued = 0; m_draw_len = 0;
      m_frames = 0; m_over = 0; m_to = 0;
   endtask

   task automatic model_update();
      if (m_ph != PH_IDLE && frame_tick) begin
         if (m_queued >= 1) m_over = 1;
         else m_queued = 1;
      end
      case (m_ph)
         PH_IDLE: if (frame_tick || m_queued > 0) begin
            m_ph = PH_DRAW; m_queued = 0; m_draw_len = 0;
         end
         PH_DRAW: begin
            m_draw_len++;
            if (bus.draw_done) m_ph = PH_FLASH;
            else if (m_draw_len == TO) begin m_ph = PH_FLASH; m_to = 1; end
         end
         PH_FLASH: if (bus.flash_done) m_ph = PH_ACK;
         default:  if (!bus.flash_done) begin m_ph = PH_IDLE; m_frames++; end
      endcase
   endtask

   task automatic half_a();
      @(negedge Clck);
      chk("cycle", act_vec(), model_vec());
   endtask

   task automatic half_b();
      @(posedge Clck);
      model_update();
      #1;
   endtask

   task automatic cycle();
      half_a();
      half_b();
   endtask

   task automatic clear_inputs();
      frame_tick     = 0;
      bus.draw_addr  = '0;
      bus.draw_data  = '0;
      bus.draw_we    = 0;
      bus.draw_done  = 0;
      bus.flash_addr = '0;
      bus.flash_done = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      Reset = 0;
      model_reset();
      repeat (2) @(posedge Clck);
      @(negedge Clck);
      chk("reset_state", act_vec(), 64'd0);
      @(posedge Clck);
      #1;
      Reset = 1;
   endtask

   task automatic do_frame();
      frame_tick = 1; cycle();
      frame_tick = 0; cycle();
      bus.draw_done = 1; cycle();
      bus.draw_done = 0; bus.flash_done = 1; cycle();
      bus.flash_done = 0; cycle();
   endtask

   vec_t tbl[10];

   initial begin
      int n;
      tbl[0] = '{0, 0, 0, 0, 5'b00000};
      tbl[1] = '{1, 0, 1, 0, 5'b00000};
      tbl[2] = '{0, 0, 0, 0, 5'b11000};
      tbl[3] = '{0, 0, 1, 0, 5'b11001};
      tbl[4] = '{0, 1, 1, 0, 5'b11001};
      tbl[5] = '{0, 0, 0, 0, 5'b10100};
      tbl[6] = '{0, 0, 1, 1, 5'b10100};
      tbl[7] = '{0, 0, 1, 1, 5'b10010};
      tbl[8] = '{0, 0, 0, 0, 5'b10010};
      tbl[9] = '{0, 0, 0, 0, 5'b00000};

      Reset = 0;
      do_reset();

      // Vector table: one complete frame from idle.
      for (int i = 0; i < 10; i++) begin
         frame_tick     = tbl[i].tick;
         bus.draw_done  = tbl[i].ddone;
         bus.draw_we    = tbl[i].dwe;
         bus.flash_done = tbl[i].fdone;
         half_a();
         chk($sformatf("table_%0d", i),
             64'({busy, bus.draw_gnt, bus.flash_start, bus.flash_ack, bus.mem_we}),
             64'(tbl[i].exp));
         half_b();
      end
      clear_inputs();
      chk("table_count", 64'(frame_count), 64'd1);

      // Scenario 1: tick, then a same-cycle drawer write.
      do_reset();
      cycle(); cycle();
      frame_tick = 1; cycle();
      frame_tick = 0;
      bus.draw_addr = 15'd5; bus.draw_data = 3'd3; bus.draw_we = 1;
      @(negedge Clck);
      chk("s1_busy_gnt", 64'({busy, bus.draw_gnt}), 64'b11);
      chk("s1_write", 64'({bus.mem_addr, bus.mem_wdata, bus.mem_we}), 64'({15'd5, 3'd3, 1'b1}));
      half_b();
      bus.draw_we = 0;

      // Scenario 2: draw_done, flasher scan, handshake back to idle.
      bus.draw_done = 1; cycle();
      bus.draw_done = 0;
      for (int a = 0; a < 19200; a++) begin
         bus.flash_addr = AW'(a);
         cycle();
      end
      bus.flash_done = 1; cycle();
      half_a();
      chk("s2_ack", 64'({bus.flash_start, bus.flash_ack}), 64'b01);
      half_b();
      cycle(); cycle();
      bus.flash_done = 0; cycle();
      half_a();
      chk("s2_idle_count", 64'({busy, frame_count}), 64'({1'b0, 8'd1}));
      half_b();

      // Scenario 3: drawer never finishes.
      frame_tick = 1; cycle();
      frame_tick = 0;
      n = 0;
      while (bus.draw_gnt === 1'b1 && n < 100) begin
         cycle();
         n++;
      end
      chk("s3_draw_cycles", 64'(n), 64'(TO));
      chk("s3_flash_to", 64'({bus.flash_start, timed_out}), 64'b11);
      bus.flash_done = 1; cycle();
      bus.flash_done = 0; cycle();

      // Scenario 4: two ticks while flashing.
      frame_tick = 1; cycle();
      frame_tick = 0; cycle();
      bus.draw_done = 1; cycle();
      bus.draw_done = 0;
      frame_tick = 1; cycle();
      frame_tick = 0;
      half_a();
      chk("s4_one_tick", 64'(overrun), 64'd0);
      half_b();
      frame_tick = 1; cycle();
      frame_tick = 0;
      half_a();
      chk("s4_overrun", 64'(overrun), 64'd1);
      half_b();
      bus.flash_done = 1; cycle();
      bus.flash_done = 0; cycle();
      half_a();
      chk("s4_idle_gap", 64'(busy), 64'd0);
      half_b();
      half_a();
      chk("s4_redraw", 64'({busy, bus.draw_gnt}), 64'b11);
      half_b();
      bus.draw_done = 1; cycle();
      bus.draw_done = 0; bus.flash_done = 1; cycle();
      bus.flash_done = 0; cycle();

      // Scenario 5: stray write strobes, then counter wrap.
      bus.draw_we = 1;
      half_a();
      chk("s5_we_idle", 64'(bus.mem_we), 64'd0);
      half_b();
      frame_tick = 1; cycle();
      frame_tick = 0;
      bus.draw_done = 1; cycle();
      bus.draw_done = 0;
      half_a();
      chk("s5_we_flash", 64'(bus.mem_we), 64'd0);
      half_b();
      bus.flash_done = 1; cycle();
      half_a();
      chk("s5_we_ack", 64'(bus.mem_we), 64'd0);
      half_b();
      bus.flash_done = 0; cycle();
      bus.draw_we = 0;

      do_reset();
      for (int f = 0; f < 255; f++) do_frame();
      chk("s5_count_255", 64'(frame_count), 64'd255);
      do_frame();
      chk("s5_count_wrap", 64'(frame_count), 64'd0);

      // Scenario 6: reset in the middle of flashing.
      frame_tick = 1; cycle();
      frame_tick = 0;
      bus.draw_done = 1; cycle();
      bus.draw_done = 0;
      bus.flash_addr = 15'h1234;
      chk("s6_in_flash", 64'(bus.flash_start), 64'd1);
      #2;
      Reset = 0;
      #1;
      chk("s6_async_zero", act_vec(), 64'd0);
      model_reset();
      clear_inputs();
      @(posedge Clck);
      #1;
      Reset = 1;
      repeat (10) cycle();
      chk("s6_stays_idle", 64'(busy), 64'd0);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         frame_tick     = ($urandom_range(0, 7) == 0);
         bus.draw_addr  = AW'($urandom);
         bus.draw_data  = CW'($urandom);
         bus.draw_we    = $urandom_range(0, 1) == 1;
         bus.draw_done  = ($urandom_range(0, 9) == 0);
         bus.flash_addr = AW'($urandom);
         bus.flash_done = ($urandom_range(0, 3) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
